wf_zoom_ctrl: RTL and testbench

Sequencer for the waveform display window. Converts button presses into a zoom-level target (0 = default window, 5 = full screen). Steps the four window limits toward that target once per video frame, so the display grows or shrinks smoothly instead of jumping. Sits between the button inputs and the waveform renderer, which consumes `start_x/end_x/start_y/end_y`.

---
 rtl/wf_pkg.sv | 43 ++++
 rtl/dffr.sv | 22 ++
 rtl/wf_axis_stepper.sv | 46 ++++
 rtl/wf_zoom_ctrl.sv | 130 +++++++++++++
 tb/tb_wf_zoom_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/wf_pkg.sv
// Shared constants, state encoding and target-window helpers for the
// waveform zoom sequencer.
package wf_pkg;

  localparam logic [9:0] DEF_START_X = 10'd138;
  localparam logic [9:0] DEF_END_X   = 10'd838;
  localparam logic [9:0] DEF_START_Y = 10'd62;
  localparam logic [9:0] DEF_END_Y   = 10'd482;

  localparam logic [9:0] MAX_START_X = 10'd88;
  localparam logic [9:0] MAX_END_X   = 10'd888;
  localparam logic [9:0] MAX_START_Y = 10'd32;
  localparam logic [9:0] MAX_END_Y   = 10'd512;

  localparam int               LEVEL_W   = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd5;

  localparam logic [9:0] EXP_X = 10'd10;
  localparam logic [9:0] EXP_Y = 10'd6;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_ANIMATE = 1'b1
  } state_e;

  // Window limits grow outward symmetrically by a fixed amount per level.
  function automatic logic [9:0] tgt_start_x(input logic [LEVEL_W-1:0] lvl);
    return DEF_START_X - (10'(lvl) * EXP_X);
  endfunction

  function automatic logic [9:0] tgt_end_x(input logic [LEVEL_W-1:0] lvl);
    return DEF_END_X + (10'(lvl) * EXP_X);
  endfunction

  function automatic logic [9:0] tgt_start_y(input logic [LEVEL_W-1:0] lvl);
    return DEF_START_Y - (10'(lvl) * EXP_Y);
  endfunction

  function automatic logic [9:0] tgt_end_y(input logic [LEVEL_W-1:0] lvl);
    return DEF_END_Y + (10'(lvl) * EXP_Y);
  endfunction

endpackage

// File: rtl/dffr.sv
// Standard register cell: D flip-flop with asynchronous active-low reset
// to a parameterised value.
module dffr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage element with async clear to RST_VAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/wf_axis_stepper.sv
// Moves one window limit toward its target when enabled. With
// WF_ZOOM_ANIM_EN defined it moves by at most i_step; otherwise it jumps.
module wf_axis_stepper (
  input  logic [9:0] i_cur,
  input  logic [9:0] i_tgt,
  input  logic [9:0] i_step,
  input  logic       i_en,
  output logic [9:0] o_nxt,
  output logic       o_at_target
);

`ifdef WF_ZOOM_ANIM_EN
  logic [9:0] w_diff;

  // Clamp the final step so the limit lands exactly on the target.
  always_comb begin
    w_diff = 10'd0;
    o_nxt  = i_cur;
    if (!i_en) begin
      o_nxt = i_cur;
    end else if (i_cur < i_tgt) begin
      w_diff = i_tgt - i_cur;
      o_nxt  = (w_diff <= i_step) ? i_tgt : (i_cur + i_step);
    end else begin
      w_diff = i_cur - i_tgt;
      o_nxt  = (w_diff <= i_step) ? i_tgt : (i_cur - i_step);
    end
  end
`else
  logic w_unused_step;
  assign w_unused_step = ^i_step;

  // Without animation the limit loads the target on the enabling tick.
  always_comb begin
    o_nxt = i_cur;
    if (i_en) begin
      o_nxt = i_tgt;
    end else begin
      o_nxt = i_cur;
    end
  end
`endif

  assign o_at_target = (o_nxt == i_tgt);

endmodule

// File: rtl/wf_zoom_ctrl.sv
// Button-driven zoom sequencer for the waveform window. Define
// WF_ZOOM_ANIM_EN for per-frame stepped animation; otherwise limits jump.
module wf_zoom_ctrl
  import wf_pkg::*;
#(
  parameter int STEP_X = 10,
  parameter int STEP_Y = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_full,
  input  logic         frame_tick,
  output logic [9:0]   start_x,
  output logic [9:0]   end_x,
  output logic [9:0]   start_y,
  output logic [9:0]   end_y,
  output logic [2:0]   level,
  output logic         busy
);

  logic [2:0]         w_btn;
  logic [2:0]         r_btn_q;
  logic [2:0]         w_press;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_level_nxt;
  logic               w_level_chg;
  logic               r_state_q;
  state_e             w_state;
  state_e             w_state_nxt;
  logic               w_tick;
  logic               w_all_at;

  logic [9:0] r_sx, r_ex, r_sy, r_ey;
  logic [9:0] w_nxt_sx, w_nxt_ex, w_nxt_sy, w_nxt_ey;
  logic       w_at_sx, w_at_ex, w_at_sy, w_at_ey;

  // Reset to all ones so a button held through reset release is not a press.
  assign w_btn = {btn_full, btn_down, btn_up};
  dffr #(.W(3), .RST_VAL(3'b111)) u_btn_q (
    .clk(clk), .rst(rst), .d(w_btn), .q(r_btn_q)
  );
  assign w_press = w_btn & ~r_btn_q;

  // Only a single isolated press is a command; simultaneous presses fall to default.
  always_comb begin
    w_level_nxt = r_level;
    case (w_press)
      3'b001:  w_level_nxt = (r_level < LEVEL_MAX) ? (r_level + 3'd1) : r_level;
      3'b010:  w_level_nxt = (r_level > 3'd0) ? (r_level - 3'd1) : r_level;
      3'b100:  w_level_nxt = (r_level == LEVEL_MAX) ? 3'd0 : LEVEL_MAX;
      default: w_level_nxt = r_level;
    endcase
  end
  assign w_level_chg = (w_level_nxt != r_level);

  dffr #(.W(LEVEL_W), .RST_VAL(3'd0)) u_level (
    .clk(clk), .rst(rst), .d(w_level_nxt), .q(r_level)
  );

  assign w_state = state_e'(r_state_q);
  assign w_tick  = (w_state == ST_ANIMATE) && frame_tick;

  // Steppers use the registered level, i.e. the target before any same-cycle command.
  wf_axis_stepper u_step_sx (
    .i_cur(r_sx), .i_tgt(tgt_start_x(r_level)), .i_step(10'(STEP_X)),
    .i_en(w_tick), .o_nxt(w_nxt_sx), .o_at_target(w_at_sx)
  );
  wf_axis_stepper u_step_ex (
    .i_cur(r_ex), .i_tgt(tgt_end_x(r_level)), .i_step(10'(STEP_X)),
    .i_en(w_tick), .o_nxt(w_nxt_ex), .o_at_target(w_at_ex)
  );
  wf_axis_stepper u_step_sy (
    .i_cur(r_sy), .i_tgt(tgt_start_y(r_level)), .i_step(10'(STEP_Y)),
    .i_en(w_tick), .o_nxt(w_nxt_sy), .o_at_target(w_at_sy)
  );
  wf_axis_stepper u_step_ey (
    .i_cur(r_ey), .i_tgt(tgt_end_y(r_level)), .i_step(10'(STEP_Y)),
    .i_en(w_tick), .o_nxt(w_nxt_ey), .o_at_target(w_at_ey)
  );
  assign w_all_at = w_at_sx & w_at_ex & w_at_sy & w_at_ey;

  dffr #(.W(10), .RST_VAL(DEF_START_X)) u_sx (
    .clk(clk), .rst(rst), .d(w_nxt_sx), .q(r_sx)
  );
  dffr #(.W(10), .RST_VAL(DEF_END_X)) u_ex (
    .clk(clk), .rst(rst), .d(w_nxt_ex), .q(r_ex)
  );
  dffr #(.W(10), .RST_VAL(DEF_START_Y)) u_sy (
    .clk(clk), .rst(rst), .d(w_nxt_sy), .q(r_sy)
  );
  dffr #(.W(10), .RST_VAL(DEF_END_Y)) u_ey (
    .clk(clk), .rst(rst), .d(w_nxt_ey), .q(r_ey)
  );

  // A retarget on the finishing tick keeps the animation running.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      ST_IDLE: begin
        if (w_level_chg) begin
          w_state_nxt = ST_ANIMATE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ANIMATE: begin
        if (w_tick && w_all_at && !w_level_chg) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ANIMATE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  dffr #(.W(1), .RST_VAL(1'b0)) u_state (
    .clk(clk), .rst(rst), .d(w_state_nxt), .q(r_state_q)
  );

  assign start_x = r_sx;
  assign end_x   = r_ex;
  assign start_y = r_sy;
  assign end_y   = r_ey;
  assign level   = r_level;
  assign busy    = r_state_q;

endmodule

// File: tb/tb_wf_zoom_ctrl.sv
// Directed self-checking bench for wf_zoom_ctrl; expectations follow the
// build's WF_ZOOM_ANIM_EN setting.
module tb_wf_zoom_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_full, frame_tick;
  logic [9:0] start_x, end_x, start_y, end_y;
  logic [2:0] level;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wf_zoom_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_full(btn_full),
    .frame_tick(frame_tick),
    .start_x(start_x), .end_x(end_x), .start_y(start_y), .end_y(end_y),
    .level(level), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic check_win(input string tag, input logic [9:0] sx, input logic [9:0] ex,
                           input logic [9:0] sy, input logic [9:0] ey, input logic bz);
    check_val({tag, "_sx"}, 32'(start_x), 32'(sx));
    check_val({tag, "_ex"}, 32'(end_x), 32'(ex));
    check_val({tag, "_sy"}, 32'(start_y), 32'(sy));
    check_val({tag, "_ey"}, 32'(end_y), 32'(ey));
    check_val({tag, "_busy"}, 32'(busy), 32'(bz));
  endtask

  // b = {full, down, up}; level/busy are checked one edge after the press.
  task automatic press_chk(input string tag, input logic [2:0] b,
                           input logic [2:0] exp_lvl, input logic exp_busy);
    {btn_full, btn_down, btn_up} = b;
    cyc();
    check_val({tag, "_level"}, 32'(level), 32'(exp_lvl));
    check_val({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    {btn_full, btn_down, btn_up} = 3'b000;
    cyc();
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (busy) tick();
    end
    check_val({tag, "_settle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    btn_up = 1'b1; btn_down = 1'b0; btn_full = 1'b0; frame_tick = 1'b0;
    repeat (3) cyc();
    check_win("reset", 10'd138, 10'd838, 10'd62, 10'd482, 1'b0);
    check_val("reset_level", 32'(level), 32'd0);
    rst = 1'b1;
    repeat (3) cyc();
    check_val("held_up_level", 32'(level), 32'd0);
    check_val("held_up_busy", 32'(busy), 32'd0);
    btn_up = 1'b0;
    cyc();

    press_chk("up1", 3'b001, 3'd1, 1'b1);
    tick();
    check_win("up1_tick", 10'd128, 10'd848, 10'd56, 10'd488, 1'b0);
    press_chk("down1", 3'b010, 3'd0, 1'b1);
    tick();
    check_win("down1_tick", 10'd138, 10'd838, 10'd62, 10'd482, 1'b0);
    press_chk("down_sat", 3'b010, 3'd0, 1'b0);

    press_chk("full", 3'b100, 3'd5, 1'b1);
`ifdef WF_ZOOM_ANIM_EN
    tick(); tick();
    check_win("full_t2", 10'd118, 10'd858, 10'd50, 10'd494, 1'b1);
    tick(); tick(); tick();
    check_win("full_t5", 10'd88, 10'd888, 10'd32, 10'd512, 1'b0);
`else
    tick();
    check_win("full_t1", 10'd88, 10'd888, 10'd32, 10'd512, 1'b0);
`endif
    tick();
    check_win("full_extra", 10'd88, 10'd888, 10'd32, 10'd512, 1'b0);
    press_chk("full_back", 3'b100, 3'd0, 1'b1);
    settle("full_back");
    check_win("full_back_done", 10'd138, 10'd838, 10'd62, 10'd482, 1'b0);

    press_chk("rt_full", 3'b100, 3'd5, 1'b1);
`ifdef WF_ZOOM_ANIM_EN
    tick(); tick();
    check_win("rt_mid", 10'd118, 10'd858, 10'd50, 10'd494, 1'b1);
    press_chk("rt_back", 3'b100, 3'd0, 1'b1);
    tick(); tick();
`else
    press_chk("rt_back", 3'b100, 3'd0, 1'b1);
    check_win("rt_pre", 10'd138, 10'd838, 10'd62, 10'd482, 1'b1);
    tick();
`endif
    check_win("rt_done", 10'd138, 10'd838, 10'd62, 10'd482, 1'b0);

    press_chk("ct_up", 3'b001, 3'd1, 1'b1);
    btn_up = 1'b1; frame_tick = 1'b1;
    cyc();
    check_win("ct_step", 10'd128, 10'd848, 10'd56, 10'd488, 1'b1);
    check_val("ct_level", 32'(level), 32'd2);
    btn_up = 1'b0; frame_tick = 1'b0;
    cyc();
    tick();
    check_win("ct_done", 10'd118, 10'd858, 10'd50, 10'd494, 1'b0);

    press_chk("back1", 3'b010, 3'd1, 1'b1);
    press_chk("back0", 3'b010, 3'd0, 1'b1);
    settle("back");
    check_win("back_done", 10'd138, 10'd838, 10'd62, 10'd482, 1'b0);

    for (int i = 1; i <= 6; i++) begin
      press_chk($sformatf("sat_up%0d", i), 3'b001, (i > 5) ? 3'd5 : 3'(i), (i <= 5));
      tick();
    end
    check_win("sat_up_done", 10'd88, 10'd888, 10'd32, 10'd512, 1'b0);

    press_chk("conf_ud", 3'b011, 3'd5, 1'b0);
    press_chk("conf_df", 3'b110, 3'd5, 1'b0);
    press_chk("conf_all", 3'b111, 3'd5, 1'b0);

    press_chk("rm_down4", 3'b010, 3'd4, 1'b1);
    tick();
    check_win("rm_l4", 10'd98, 10'd878, 10'd38, 10'd506, 1'b0);
    press_chk("rm_down3", 3'b010, 3'd3, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_win("rst_mid", 10'd138, 10'd838, 10'd62, 10'd482, 1'b0);
    check_val("rst_mid_level", 32'(level), 32'd0);
    rst = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
